// File: rtl/umi_pkt_fifo.sv
// umi_pkt_fifo
//   Elastic first-word-fall-through buffer for UMI packets, placed between a
//   simulator-paced queue endpoint and a UMI port of the device under test.
//   Optional statistics (high-water mark, stall cycle counter) are compiled in
//   when the macro UMI_PKT_FIFO_STATS_EN is defined; otherwise hwm and
//   stall_cycles read as zero and stats_clear is ignored.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          asynchronous active-high reset
//   flush        synchronous discard of all stored packets (beats handshakes)
//   in_valid     upstream packet valid
//   in_packet    upstream packet, UW bits
//   in_ready     FIFO can accept a packet (registered state and flush only)
//   out_valid    head packet valid
//   out_packet   head packet, UW bits, combinational from storage
//   out_ready    downstream accepts head
//   count        current occupancy 0..DEPTH
//   hwm          max occupancy since reset/stats_clear
//   stall_cycles cycles with out_valid && !out_ready, saturating
//   stats_clear  synchronous clear of hwm and stall_cycles
module umi_pkt_fifo #(
  parameter int UW    = 256,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [UW-1:0] in_packet,
  output logic          in_ready,
  output logic          out_valid,
  output logic [UW-1:0] out_packet,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic [CW-1:0] hwm,
  output logic [31:0]   stall_cycles,
  input  logic          stats_clear
);

  localparam int AW = $clog2(DEPTH);

  logic [UW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  assign in_ready   = !flush && (count_q != CW'(DEPTH));
  assign out_valid  = (count_q != '0);
  assign out_packet = mem_q[rd_ptr_q];
  assign count      = count_q;

  // in_ready already folds in flush, so a flush cycle can never write storage
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_packet;
  end

`ifdef UMI_PKT_FIFO_STATS_EN
  logic [CW-1:0] hwm_q, hwm_d;
  logic [31:0]   stall_q, stall_d;

  always_comb begin
    hwm_d   = hwm_q;
    stall_d = stall_q;
    if (stats_clear) begin
      hwm_d   = '0;
      stall_d = '0;
    end else begin
      // tracks the occupancy that will exist after this edge
      if (count_d > hwm_q) hwm_d = count_d;
      if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      hwm_q   <= hwm_d;
      stall_q <= stall_d;
    end
  end

  assign hwm          = hwm_q;
  assign stall_cycles = stall_q;
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign hwm                = '0;
  assign stall_cycles       = '0;
`endif

endmodule
